// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - decode inputs and control outputs between mc_ctrl (master) and the datapath (slave)
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             dm_ready;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             rf_we;
    logic [1:0]       rf_wa_sel;
    logic [1:0]       rf_wd_sel;
    logic             alu_src;
    logic [2:0]       alu_op;
    logic             ext_op;
    logic             dm_we;
    logic             dm_re;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, dm_ready,
        output pc_we, pc_sel, ir_we, rf_we, rf_wa_sel, rf_wd_sel,
               alu_src, alu_op, ext_op, dm_we, dm_re, state, illegal, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, dm_ready,
        input  pc_we, pc_sel, ir_we, rf_we, rf_wa_sel, rf_wd_sel,
               alu_src, alu_op, ext_op, dm_we, dm_re, state, illegal, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB); MC_CTRL_MEM_WAIT_EN stalls MEM on dm_ready
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  m
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t           st;
    state_t           nxt;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    logic is_r;
    logic d_addu, d_subu, d_jr, d_nop;
    logic d_ori, d_lui, d_lw, d_sw, d_beq, d_j, d_jal;
    logic d_legal;

    logic       exe_alu_src;
    logic       exe_ext_op;
    logic [2:0] exe_alu_op;
    logic       mem_go;

    logic       pc_we_c, ir_we_c, rf_we_c, dm_we_c, dm_re_c;
    logic [1:0] pc_sel_c, rf_wa_sel_c, rf_wd_sel_c;
    logic       alu_src_c, ext_op_c;
    logic [2:0] alu_op_c;
    logic       retire, set_illegal;

    assign is_r   = (m.opcode == 6'b000000);
    assign d_addu = is_r && (m.funct == 6'b100001);
    assign d_subu = is_r && (m.funct == 6'b100011);
    assign d_jr   = is_r && (m.funct == 6'b001000);
    assign d_nop  = is_r && (m.funct == 6'b000000);
    assign d_ori  = (m.opcode == 6'b001101);
    assign d_lui  = (m.opcode == 6'b001111);
    assign d_lw   = (m.opcode == 6'b100011);
    assign d_sw   = (m.opcode == 6'b101011);
    assign d_beq  = (m.opcode == 6'b000100);
    assign d_j    = (m.opcode == 6'b000010);
    assign d_jal  = (m.opcode == 6'b000011);
    assign d_legal = d_addu | d_subu | d_jr | d_nop | d_ori | d_lui |
                     d_lw | d_sw | d_beq | d_j | d_jal;

    // ALU/EXT selects chosen in EXE are held unchanged through MEM and WB
    assign exe_alu_src = d_ori | d_lui | d_lw | d_sw;
    assign exe_ext_op  = d_lw | d_sw | d_beq;
    always_comb begin
        exe_alu_op = 3'b000;
        if (d_subu || d_beq) exe_alu_op = 3'b001;
        else if (d_ori)      exe_alu_op = 3'b010;
        else if (d_lui)      exe_alu_op = 3'b011;
    end

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_go = m.dm_ready;
`else
    // dm_ready has no effect without the wait option
    assign mem_go = m.dm_ready | 1'b1;
`endif

    always_comb begin
        nxt         = S_IF;
        pc_we_c     = 1'b0;
        pc_sel_c    = 2'b00;
        ir_we_c     = 1'b0;
        rf_we_c     = 1'b0;
        rf_wa_sel_c = 2'b00;
        rf_wd_sel_c = 2'b00;
        alu_src_c   = 1'b0;
        alu_op_c    = 3'b000;
        ext_op_c    = 1'b0;
        dm_we_c     = 1'b0;
        dm_re_c     = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (st)
            S_IF: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                nxt     = S_ID;
            end
            S_ID: begin
                if (d_j || d_jal) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = 2'b10;
                end
                if (d_jal) begin
                    rf_we_c     = 1'b1;
                    rf_wa_sel_c = 2'b10;
                    rf_wd_sel_c = 2'b10;
                end
                if (d_jr) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = 2'b11;
                end
                if (d_nop || d_j || d_jal || d_jr) retire = 1'b1;
                else if (d_legal)                  nxt = S_EXE;
                else                               set_illegal = 1'b1;
            end
            S_EXE: begin
                alu_src_c = exe_alu_src;
                ext_op_c  = exe_ext_op;
                alu_op_c  = exe_alu_op;
                if (d_beq) begin
                    if (m.zero) begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = 2'b01;
                    end
                    retire = 1'b1;
                end else if (d_lw || d_sw) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                alu_src_c = exe_alu_src;
                ext_op_c  = exe_ext_op;
                alu_op_c  = exe_alu_op;
                dm_re_c   = d_lw;
                dm_we_c   = d_sw;
                if (!mem_go)   nxt = S_MEM;
                else if (d_lw) nxt = S_WB;
                else           retire = d_sw;
            end
            S_WB: begin
                alu_src_c   = exe_alu_src;
                ext_op_c    = exe_ext_op;
                alu_op_c    = exe_alu_op;
                rf_we_c     = 1'b1;
                rf_wa_sel_c = is_r ? 2'b01 : 2'b00;
                rf_wd_sel_c = d_lw ? 2'b01 : 2'b00;
                retire      = 1'b1;
            end
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st        <= S_IF;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            st <= nxt;
            if (set_illegal) illegal_q <= 1'b1;
            if (retire)      cnt_q     <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Enables are gated by reset so an abandoned instruction writes nothing
    assign m.pc_we     = pc_we_c & reset;
    assign m.ir_we     = ir_we_c & reset;
    assign m.rf_we     = rf_we_c & reset;
    assign m.dm_we     = dm_we_c & reset;
    assign m.dm_re     = dm_re_c & reset;
    assign m.pc_sel    = pc_sel_c;
    assign m.rf_wa_sel = rf_wa_sel_c;
    assign m.rf_wd_sel = rf_wd_sel_c;
    assign m.alu_src   = alu_src_c;
    assign m.alu_op    = alu_op_c;
    assign m.ext_op    = ext_op_c;
    assign m.state     = st;
    assign m.illegal   = illegal_q;
    assign m.instr_cnt = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - vector table, hand sequences and random instruction stream against a phase-list model
module tb_mc_ctrl;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(CW)) bus();
    mc_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .m(bus));

    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;
    logic model_ill = 1'b0;

    typedef enum int {C_NOP, C_J, C_JAL, C_JR, C_ADDU, C_SUBU, C_ORI, C_LUI,
                      C_LW, C_SW, C_BEQ, C_BAD} cls_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lat;
    } vec_t;

    vec_t        tbl [14];
    logic [18:0] ex [0:4];
    int          ex_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] mk(input logic pw, input logic [1:0] ps, input logic iw,
                                       input logic rw, input logic [1:0] wa, input logic [1:0] wd,
                                       input logic as, input logic [2:0] ao, input logic eo,
                                       input logic dw, input logic dr, input logic [2:0] st);
        return {pw, ps, iw, rw, wa, wd, as, ao, eo, dw, dr, st};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.pc_we, bus.pc_sel, bus.ir_we, bus.rf_we, bus.rf_wa_sel, bus.rf_wd_sel,
                bus.alu_src, bus.alu_op, bus.ext_op, bus.dm_we, bus.dm_re, bus.state};
    endfunction

    function automatic logic [4:0] enables();
        return {bus.pc_we, bus.ir_we, bus.rf_we, bus.dm_we, bus.dm_re};
    endfunction

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        cls_t c;
        case (op)
            6'b000000: case (fn)
                6'b100001: c = C_ADDU;
                6'b100011: c = C_SUBU;
                6'b001000: c = C_JR;
                6'b000000: c = C_NOP;
                default:   c = C_BAD;
            endcase
            6'b001101: c = C_ORI;
            6'b001111: c = C_LUI;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b000010: c = C_J;
            6'b000011: c = C_JAL;
            default:   c = C_BAD;
        endcase
        return c;
    endfunction

    // Expected control word for each phase the instruction passes through
    task automatic build(input cls_t c, input logic z);
        logic       as;
        logic       eo;
        logic       tk;
        logic [2:0] ao;
        as = (c == C_ORI || c == C_LUI || c == C_LW || c == C_SW);
        eo = (c == C_LW || c == C_SW || c == C_BEQ);
        ao = (c == C_SUBU || c == C_BEQ) ? 3'b001 : (c == C_ORI) ? 3'b010 :
             (c == C_LUI) ? 3'b011 : 3'b000;
        tk = (c == C_BEQ) && z;
        ex[0] = mk(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0);
        case (c)
            C_J:     ex[1] = mk(1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd1);
            C_JAL:   ex[1] = mk(1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd1);
            C_JR:    ex[1] = mk(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd1);
            default: ex[1] = mk(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd1);
        endcase
        if (c == C_NOP || c == C_J || c == C_JAL || c == C_JR || c == C_BAD) begin
            ex_n = 2;
        end else begin
            ex[2] = mk(tk, tk ? 2'b01 : 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, as, ao, eo, 1'b0, 1'b0, 3'd2);
            if (c == C_BEQ) begin
                ex_n = 3;
            end else if (c == C_LW || c == C_SW) begin
                ex[3] = mk(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, as, ao, eo, c == C_SW, c == C_LW, 3'd3);
                ex[4] = mk(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, as, ao, eo, 1'b0, 1'b0, 3'd4);
                ex_n  = (c == C_SW) ? 4 : 5;
            end else begin
                ex[3] = mk(1'b0, 2'b00, 1'b0, 1'b1, (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00,
                           2'b00, as, ao, eo, 1'b0, 1'b0, 3'd4);
                ex_n  = 4;
            end
        end
    endtask

    // hold >= 0: dm_ready low for the first 'hold' MEM cycles; hold < 0: random dm_ready
    // lat < 0: take latency from the phase list instead of a stated constant
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int lat, input int hold, input string name);
        cls_t c;
        int   p;
        int   cyc;
        int   waits;
        int   mem_seen;
        logic rdy;
        c = classify(op, fn);
        build(c, z);
        p = 0; cyc = 0; waits = 0; mem_seen = 0;
        while (p < ex_n && cyc < 64) begin
            bus.opcode = op;
            bus.funct  = fn;
            bus.zero   = z;
            if (ex[p][2:0] == 3'd3) begin
                rdy = (hold >= 0) ? (mem_seen >= hold) : ($urandom_range(0, 2) != 0);
                mem_seen++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            bus.dm_ready = rdy;
            @(negedge clk);
            chk({name, " ctl"}, 32'(obs()), 32'(ex[p]));
`ifdef MC_CTRL_MEM_WAIT_EN
            if (ex[p][2:0] == 3'd3 && !rdy) waits++;
            else p++;
`else
            p++;
`endif
            cyc++;
            @(posedge clk);
            #1;
        end
        if (c != C_BAD) model_cnt = (model_cnt + 1) % (1 << CW);
        else            model_ill = 1'b1;
        chk({name, " lat"}, 32'(cyc), 32'(((lat < 0) ? ex_n : lat) + waits));
        chk({name, " state"}, 32'(bus.state), 32'd0);
        chk({name, " cnt"}, 32'(bus.instr_cnt), 32'(model_cnt));
        chk({name, " ill"}, 32'(bus.illegal), 32'(model_ill));
    endtask

    // lw interrupted by reset after ncyc cycles; dm_ready held low so a wait build sits in MEM
    task automatic reset_mid(input int ncyc, input string name);
        bus.opcode   = 6'b100011;
        bus.funct    = 6'b000000;
        bus.zero     = 1'b0;
        bus.dm_ready = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk({name, " en"}, 32'(enables()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        bus.dm_ready = 1'b1;
        model_cnt = 0;
        model_ill = 1'b0;
        chk({name, " state"}, 32'(bus.state), 32'd0);
        chk({name, " cnt"}, 32'(bus.instr_cnt), 32'd0);
        chk({name, " ill"}, 32'(bus.illegal), 32'd0);
    endtask

    initial begin
        bus.opcode = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.dm_ready = 1'b1;
        tbl[0]  = '{6'b001101, 6'b000000, 1'b0, 4};
        tbl[1]  = '{6'b000000, 6'b100001, 1'b0, 4};
        tbl[2]  = '{6'b101011, 6'b000000, 1'b0, 4};
        tbl[3]  = '{6'b100011, 6'b000000, 1'b0, 5};
        tbl[4]  = '{6'b000100, 6'b000000, 1'b1, 3};
        tbl[5]  = '{6'b000100, 6'b000000, 1'b0, 3};
        tbl[6]  = '{6'b000011, 6'b000000, 1'b0, 2};
        tbl[7]  = '{6'b000000, 6'b001000, 1'b0, 2};
        tbl[8]  = '{6'b111111, 6'b000000, 1'b0, 2};
        tbl[9]  = '{6'b000000, 6'b000000, 1'b0, 2};
        tbl[10] = '{6'b000010, 6'b000000, 1'b0, 2};
        tbl[11] = '{6'b000000, 6'b100011, 1'b0, 4};
        tbl[12] = '{6'b001111, 6'b000000, 1'b0, 4};
        tbl[13] = '{6'b000000, 6'b101010, 1'b0, 2};

        @(negedge clk);
        chk("rst en0", 32'(enables()), 32'd0);
        @(negedge clk);
        chk("rst en1", 32'(enables()), 32'd0);
        chk("rst state", 32'(bus.state), 32'd0);
        chk("rst cnt", 32'(bus.instr_cnt), 32'd0);
        chk("rst ill", 32'(bus.illegal), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 14; i++)
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].lat, 0, $sformatf("vec%0d", i));

        reset_mid(2, "rst_exe");
        run_instr(6'b100011, 6'b000000, 1'b0, 5, 3, "lw_hold3");
        reset_mid(4, "rst_late");
        run_instr(6'b001101, 6'b000000, 1'b0, 4, 0, "ori_after_rst");

        for (int i = 0; i < 200; i++) begin
            int         k;
            logic [5:0] op;
            logic [5:0] fn;
            k = $urandom_range(0, 15);
            if (k < 14) begin
                op = tbl[k].op;
                fn = tbl[k].fn;
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn, 1'($urandom_range(0, 1)), -1, -1, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
